// File: rtl/button_event_queue_if.sv
// Button event queue bus: debounce/acknowledge pairs and processor pop port.
interface button_event_queue_if #(
  parameter int NUM_BUTTONS = 4,
  parameter int CODE_WIDTH  = 2,
  parameter int PTR_WIDTH   = 3
);
  logic [NUM_BUTTONS-1:0] debounce;
  logic [NUM_BUTTONS-1:0] acknowledge;
  logic                   read_event;
  logic                   event_valid;
  logic [CODE_WIDTH-1:0]  event_code;
  logic [PTR_WIDTH:0]     event_count;

  // Debounce units and processor side.
  modport master (
    output debounce,
    output read_event,
    input  acknowledge,
    input  event_valid,
    input  event_code,
    input  event_count
  );

  // Queue side.
  modport slave (
    input  debounce,
    input  read_event,
    output acknowledge,
    output event_valid,
    output event_code,
    output event_count
  );
endinterface

// File: rtl/button_event_queue.sv
// Edge-detects debounced button levels and queues button-index codes in an
// in-order show-ahead FIFO drained one entry per cycle by the processor.
module button_event_queue #(
  parameter int NUM_BUTTONS = 4,
  parameter int CODE_WIDTH  = 2,
  parameter int DEPTH       = 8,
  parameter int PTR_WIDTH   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  button_event_queue_if.slave  bus
);

  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
  // Highest fill level at which every button can still be granted a slot.
  localparam logic [PTR_WIDTH:0] ACK_LIMIT = (PTR_WIDTH+1)'(DEPTH - NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0] prev_q;
  logic [NUM_BUTTONS-1:0] pending_q;
  logic [CODE_WIDTH-1:0]  storage [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q;
  logic [PTR_WIDTH-1:0]   rd_ptr_q;
  logic [PTR_WIDTH:0]     count_q;

  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] cand;
  logic [NUM_BUTTONS-1:0] push_mask;
  logic [CODE_WIDTH-1:0]  push_idx;
  logic                   push;
  logic                   pop;

  // Pick the lowest-index candidate and decide whether push/pop happen.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rise      = bus.debounce & ~prev_q;
    cand      = pending_q | rise;
    push_idx  = '0;
    push_mask = '0;
    // Descending scan so the lowest set index is the final assignment.
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        push_idx     = CODE_WIDTH'(i);
        push_mask    = '0;
        push_mask[i] = 1'b1;
      end
    end
    pop  = bus.read_event && (count_q != '0);
    push = (cand != '0) && ((count_q < DEPTH_CNT) || pop);
  end

  // Control state: edge history, pending presses, pointers and fill count.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q    <= '1;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      prev_q    <= bus.debounce;
      pending_q <= push ? (cand & ~push_mask) : cand;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: storage has no reset; count and pointers alone define which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push) storage[wr_ptr_q] <= push_idx;
  end

  // Outputs: acknowledge only when no press is pending and room is guaranteed.
  always_comb begin
    bus.acknowledge = ~pending_q & {NUM_BUTTONS{count_q <= ACK_LIMIT}};
    bus.event_valid = (count_q != '0);
    bus.event_code  = storage[rd_ptr_q];
    bus.event_count = count_q;
  end

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench for button_event_queue using a scoreboard of expected codes.
module tb_button_event_queue;

  localparam int NB = 4;
  localparam int CW = 2;
  localparam int DP = 8;
  localparam int PW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  button_event_queue_if #(.NUM_BUTTONS(NB), .CODE_WIDTH(CW), .PTR_WIDTH(PW)) bus ();

  button_event_queue #(
    .NUM_BUTTONS(NB), .CODE_WIDTH(CW), .DEPTH(DP), .PTR_WIDTH(PW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare head against scoreboard, then pop it with a one-cycle strobe.
  task automatic do_pop(input string tag);
    check({tag, "_valid"}, int'(bus.event_valid), 1);
    if (sb.size() != 0) check({tag, "_code"}, int'(bus.event_code), sb.pop_front());
    bus.read_event = 1'b1;
    tick();
    bus.read_event = 1'b0;
  endtask

  // Single press of button b (rise, then release); optional same-cycle pop.
  task automatic press(input int b, input bit with_pop);
    if (with_pop) begin
      check("pp_valid", int'(bus.event_valid), 1);
      if (sb.size() != 0) check("pp_code", int'(bus.event_code), sb.pop_front());
      bus.read_event = 1'b1;
    end
    bus.debounce[b] = 1'b1;
    tick();
    bus.read_event  = 1'b0;
    bus.debounce[b] = 1'b0;
    sb.push_back(b);
    tick();
  endtask

  initial begin
    bus.debounce   = '0;
    bus.read_event = 1'b0;

    // Reset, then idle.
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    check("idle_valid", int'(bus.event_valid), 0);
    check("idle_count", int'(bus.event_count), 0);
    check("idle_ack",   int'(bus.acknowledge), 4'b1111);

    // Single press of button 2, held high.
    bus.debounce[2] = 1'b1;
    tick();
    sb.push_back(2);
    check("p2_valid", int'(bus.event_valid), 1);
    check("p2_code",  int'(bus.event_code), 2);
    check("p2_count", int'(bus.event_count), 1);
    tick(); tick();
    check("p2_held_count", int'(bus.event_count), 1);
    do_pop("p2_pop");
    check("p2_after_pop", int'(bus.event_count), 0);
    bus.debounce[2] = 1'b0;
    tick();

    // Simultaneous rises of 3 and 0: 0 first, 3 pending.
    bus.debounce = 4'b1001;
    tick();
    check("sim_count1", int'(bus.event_count), 1);
    check("sim_code1",  int'(bus.event_code), 0);
    check("sim_ack1",   int'(bus.acknowledge), 4'b0111);
    tick();
    sb.push_back(0);
    sb.push_back(3);
    check("sim_count2", int'(bus.event_count), 2);
    check("sim_ack2",   int'(bus.acknowledge), 4'b1111);
    bus.debounce = 4'b0000;
    do_pop("sim_pop0");
    do_pop("sim_pop1");
    check("sim_empty", int'(bus.event_count), 0);

    // Five events without reads: acknowledge drops above DEPTH-NUM_BUTTONS.
    for (int i = 0; i < 5; i++) press(i % NB, 1'b0);
    check("five_count", int'(bus.event_count), 5);
    check("five_ack",   int'(bus.acknowledge), 4'b0000);
    do_pop("five_pop");
    check("four_count", int'(bus.event_count), 4);
    check("four_ack",   int'(bus.acknowledge), 4'b1111);
    while (sb.size() != 0) do_pop("drain_a");
    check("drain_a_count", int'(bus.event_count), 0);

    // Empty + push + pop in the same cycle: pop ignored, push lands.
    bus.read_event  = 1'b1;
    bus.debounce[1] = 1'b1;
    tick();
    bus.read_event  = 1'b0;
    bus.debounce[1] = 1'b0;
    sb.push_back(1);
    check("ep_count", int'(bus.event_count), 1);
    check("ep_code",  int'(bus.event_code), 1);
    do_pop("ep_pop");

    // Fill to DEPTH.
    for (int i = 0; i < DP; i++) press((i + 1) % NB, 1'b0);
    check("full_count", int'(bus.event_count), DP);
    // Press while full stays pending; ack all low.
    bus.debounce[2] = 1'b1;
    tick();
    bus.debounce[2] = 1'b0;
    tick();
    check("stall_count", int'(bus.event_count), DP);
    check("stall_ack",   int'(bus.acknowledge), 4'b0000);
    // Pop frees a slot; the pending press lands on the same edge.
    do_pop("stall_pop");
    sb.push_back(2);
    check("stall_refill", int'(bus.event_count), DP);
    // Full + push + pop: count stays at DEPTH.
    press(3, 1'b1);
    check("fpp_count", int'(bus.event_count), DP);
    while (sb.size() != 0) do_pop("drain_b");
    check("drain_b_count", int'(bus.event_count), 0);
    // Pop while empty is ignored.
    bus.read_event = 1'b1;
    tick();
    bus.read_event = 1'b0;
    check("empty_pop_count", int'(bus.event_count), 0);
    check("empty_pop_valid", int'(bus.event_valid), 0);

    // 20 staggered presses with interleaved pops across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      press(int'($urandom_range(0, NB - 1)), (i % 3 == 2) && (sb.size() != 0));
      check("stress_le8",  int'(bus.event_count <= 4'(DP)), 1);
      check("stress_cnt",  int'(bus.event_count), sb.size());
      if (sb.size() >= 3 || $urandom_range(0, 1) == 1) do_pop("stress_pop");
    end
    while (sb.size() != 0) do_pop("drain_c");
    check("drain_c_count", int'(bus.event_count), 0);

    // Reset mid-operation with button 1 held high.
    press(0, 1'b0);
    press(2, 1'b0);
    bus.debounce[1] = 1'b1;
    tick();
    sb.push_back(1);
    check("rst_pre_count", int'(bus.event_count), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("rst_count", int'(bus.event_count), 0);
    check("rst_valid", int'(bus.event_valid), 0);
    check("rst_ack",   int'(bus.acknowledge), 4'b1111);
    repeat (4) tick();
    check("rst_held_count", int'(bus.event_count), 0);
    bus.debounce[1] = 1'b0;
    tick();
    bus.debounce[1] = 1'b1;
    tick();
    sb.push_back(1);
    check("rst_repress_count", int'(bus.event_count), 1);
    do_pop("rst_pop");
    check("final_count", int'(bus.event_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
